// File: rtl/seg7_pkg.sv
// Shared constants and the hex font for the 8-digit 7-segment scan driver.
// Segments are active-low, ordered g..a in CA[6:0].
package seg7_pkg;

    localparam int DIGITS = 8;
    localparam int DIG_W  = $clog2(DIGITS);

    localparam logic [6:0] CA_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;

    function automatic logic [6:0] seg7_font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = CA_OFF;
        unique case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational nibble to active-low segment pattern.
// Thin wrapper so the font can be swapped without touching the scanner.
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg7_font(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit 7-segment scanner with double-buffered value,
// per-slot blanking gap, per-digit mask and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_i,
    input  logic        load_i,
    input  logic [7:0]  blank_i,
    input  logic        lz_en_i,
    output logic [7:0]  AN,
    output logic [6:0]  CA,
    output logic        frame_o
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIG_W-1:0] digit_q, digit_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      active_q, active_d;
    logic             start_q, start_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       ca_q, ca_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       font_seg;
    logic [31:0]      upper;
    logic             lz_hit;
    logic             suppress;
    logic [7:0]       an_drive;

    seg7_hex_font u_font (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

    // start_q treats the slot after reset as the last digit, so the first
    // tick opens a frame on digit 0 and commits the shadow.
    always_comb begin
        tick = (div_cnt_q == CNT_MAX);
        wrap = tick && (start_q || (digit_q == DIG_MAX));
        nibble = active_q[{digit_q, 2'b00} +: 4];
        upper = active_q >> {digit_q, 2'b00};
        lz_hit = lz_en_i && (digit_q != '0) && (upper == '0);
        suppress = blank_i[digit_q] || lz_hit;
        an_drive = ~(8'd1 << digit_q);
    end

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        digit_d   = digit_q;
        shadow_d  = load_i ? value_i : shadow_q;
        active_d  = active_q;
        start_d   = start_q;
        an_d      = AN_OFF;
        ca_d      = CA_OFF;
        if (tick) begin
            start_d = 1'b0;
            digit_d = wrap ? '0 : digit_q + 1'b1;
        end
        if (wrap) begin
            active_d = load_i ? value_i : shadow_q;
        end
        if (!tick && !start_q && !suppress) begin
            an_d = an_drive;
            ca_d = font_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            digit_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            start_q   <= 1'b1;
            an_q      <= AN_OFF;
            ca_q      <= CA_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            digit_q   <= digit_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            start_q   <= start_d;
            an_q      <= an_d;
            ca_q      <= ca_d;
        end
    end

    assign AN      = an_q;
    assign CA      = ca_q;
    assign frame_o = wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at REFRESH_DIV=4.
// Checks reset, frame timing, scan order, buffering, lz and blank masks.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] value_i;
    logic        load_i;
    logic [7:0]  blank_i;
    logic        lz_en_i;
    logic [7:0]  AN;
    logic [6:0]  CA;
    logic        frame_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .load_i  (load_i),
        .blank_i (blank_i),
        .lz_en_i (lz_en_i),
        .AN      (AN),
        .CA      (CA),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic sup(input logic [31:0] v, input int k);
        logic z;
        z = 1'b1;
        for (int n = k; n < 8; n++)
            if (v[4*n +: 4] != 4'h0) z = 1'b0;
        return blank_i[k] || (lz_en_i && k > 0 && z);
    endfunction

    function automatic logic [7:0] exp_an(input logic [31:0] v, input int k);
        return sup(v, k) ? 8'hFF : ~(8'h01 << k);
    endfunction

    function automatic logic [6:0] exp_ca(input logic [31:0] v, input int k);
        return sup(v, k) ? 7'h7F : FONT[v[4*k +: 4]];
    endfunction

    // Starts at the negedge of a frame tick; ends at the next one.
    task automatic scan_frame(input logic [31:0] val, input int ld_slot,
                              input logic [31:0] ld_val);
        for (int k = 0; k < 8; k++) begin
            step();
            load_i = 1'b0;
            check($sformatf("gap_an%0d", k), AN, 8'hFF);
            check($sformatf("gap_ca%0d", k), CA, 7'h7F);
            for (int j = 0; j < 3; j++) begin
                step();
                load_i = 1'b0;
                check($sformatf("an_d%0d_c%0d", k, j), AN, exp_an(val, k));
                check($sformatf("ca_d%0d_c%0d", k, j), CA, exp_ca(val, k));
                if (k < 7) check($sformatf("nofrm_d%0d", k), frame_o, 1'b0);
                if (k == ld_slot && j == 0) begin
                    value_i = ld_val;
                    load_i  = 1'b1;
                end
            end
        end
        check("frame_end", frame_o, 1'b1);
    endtask

    initial begin
        int lat;
        rst = 1'b0;
        value_i = '0;
        load_i = 1'b0;
        blank_i = '0;
        lz_en_i = 1'b0;
        repeat (3) step();
        check("rst_an", AN, 8'hFF);
        check("rst_ca", CA, 7'h7F);
        check("rst_frame", frame_o, 1'b0);

        rst = 1'b1;
        value_i = 32'h12345678;
        load_i = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            load_i = 1'b0;
            lat++;
            check("pre_an", AN, 8'hFF);
            if (frame_o) break;
        end
        check("first_frame_lat", lat, 3);

        scan_frame(32'h12345678, 0, 32'h000000A0);
        lz_en_i = 1'b1;
        scan_frame(32'h000000A0, 0, 32'h12345678);
        lz_en_i = 1'b0;
        scan_frame(32'h12345678, 3, 32'hFFFFFFFF);
        blank_i = 8'h01;
        scan_frame(32'hFFFFFFFF, -1, 32'h0);
        blank_i = 8'h00;
        value_i = 32'h89ABCDEF;
        load_i = 1'b1;
        scan_frame(32'h89ABCDEF, -1, 32'h0);

        step();
        step();
        check("pre_rst_an", AN, 8'hFE);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_an", AN, 8'hFF);
        check("mid_rst_ca", CA, 7'h7F);
        check("mid_rst_frame", frame_o, 1'b0);
        step();
        check("held_rst_an", AN, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
